// File: rtl/uart_pkg.sv
// Shared UART types and oversampling constants.
package uart_pkg;

  // Receiver sample ticks per bit and the tick index that lands mid-bit.
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_ERROR
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Receiver oversample tick and transmitter bit tick generator.
// Each divider is held at zero by its clear input so ticks stay phase-aligned
// to the start of a frame.
module uart_baud_gen #(
  parameter int unsigned CLOCK_RATE    = 12000000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned RX_OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_clr_i,
  input  logic tx_clr_i,
  output logic rx_tick_o,
  output logic tx_tick_o
);

  localparam int unsigned RX_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
  localparam int unsigned TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned RX_CW  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int unsigned TX_CW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

  localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(RX_DIV - 1);
  localparam logic [TX_CW-1:0] TX_LAST = TX_CW'(TX_DIV - 1);

  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;

  // Next divider values: wrap on the terminal count or hold at zero when cleared.
  always_comb begin
    rx_cnt_d = rx_cnt_q + RX_CW'(1);
    if (rx_clr_i || rx_cnt_q == RX_LAST) rx_cnt_d = '0;
    tx_cnt_d = tx_cnt_q + TX_CW'(1);
    if (tx_clr_i || tx_cnt_q == TX_LAST) tx_cnt_d = '0;
  end

  // Divider registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign rx_tick_o = !rx_clr_i && (rx_cnt_q == RX_LAST);
  assign tx_tick_o = !tx_clr_i && (tx_cnt_q == TX_LAST);

endmodule

// File: rtl/uart_8.sv
// 8N1 UART: oversampling receiver with framing-error detection and a
// bit-timed transmitter.
module uart_8 import uart_pkg::*; #(
  parameter int unsigned CLOCK_RATE    = 12000000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned RX_OVERSAMPLE = OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  logic rx_tick, tx_tick, rx_clr, tx_clr;

  rx_state_e  rx_state_q;
  logic       rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [3:0] rx_ticks_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic       rx_busy_q, rx_done_q, rx_err_q;
  logic [7:0] rx_out_q;
  logic       rx_fall;

  tx_state_e  tx_state_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;
  logic       tx_busy_q, tx_done_q, tx_out_q;

  assign rx_clr = (rx_state_q == RX_IDLE) || (rx_state_q == RX_ERROR);
  assign tx_clr = (tx_state_q == TX_IDLE);

  uart_baud_gen #(
    .CLOCK_RATE   (CLOCK_RATE),
    .BAUD_RATE    (BAUD_RATE),
    .RX_OVERSAMPLE(RX_OVERSAMPLE)
  ) u_baud (
    .clk_i    (clk),
    .rst_i    (reset),
    .rx_clr_i (rx_clr),
    .tx_clr_i (tx_clr),
    .rx_tick_o(rx_tick),
    .tx_tick_o(tx_tick)
  );

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  // The history flop runs even while disabled so a line already low at
  // enable time never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= rxIn;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  assign rx_fall = rx_prev_q && !rx_sync2_q;

  // Receiver FSM: start-edge hunt, mid-bit sampling, stop-bit validation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_ticks_q <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_busy_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_out_q   <= '0;
    end else begin
      rx_done_q <= 1'b0;
      if (!rxEn) begin
        rx_state_q <= RX_IDLE;
        rx_busy_q  <= 1'b0;
        rx_err_q   <= 1'b0;
      end else begin
        case (rx_state_q)
          RX_IDLE: begin
            if (rx_fall) begin
              rx_state_q <= RX_START;
              rx_ticks_q <= '0;
              rx_busy_q  <= 1'b1;
            end
          end
          RX_START: begin
            if (rx_tick) begin
              if (rx_ticks_q == MID_LAST) begin
                rx_ticks_q <= '0;
                if (!rx_sync2_q) begin
                  rx_state_q <= RX_DATA;
                  rx_bit_q   <= '0;
                end else begin
                  rx_state_q <= RX_IDLE;
                  rx_busy_q  <= 1'b0;
                end
              end else begin
                rx_ticks_q <= rx_ticks_q + 4'd1;
              end
            end
          end
          RX_DATA: begin
            if (rx_tick) begin
              if (rx_ticks_q == BIT_LAST) begin
                rx_ticks_q <= '0;
                rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                else                  rx_bit_q   <= rx_bit_q + 3'd1;
              end else begin
                rx_ticks_q <= rx_ticks_q + 4'd1;
              end
            end
          end
          RX_STOP: begin
            if (rx_tick) begin
              if (rx_ticks_q == BIT_LAST) begin
                rx_ticks_q <= '0;
                rx_busy_q  <= 1'b0;
                if (rx_sync2_q) begin
                  rx_out_q   <= rx_shift_q;
                  rx_done_q  <= 1'b1;
                  rx_state_q <= RX_IDLE;
                end else begin
                  rx_err_q   <= 1'b1;
                  rx_state_q <= RX_ERROR;
                end
              end else begin
                rx_ticks_q <= rx_ticks_q + 4'd1;
              end
            end
          end
          RX_ERROR: begin
            if (rx_sync2_q) begin
              rx_err_q   <= 1'b0;
              rx_state_q <= RX_IDLE;
            end
          end
          default: begin
            rx_state_q <= RX_IDLE;
            rx_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Transmitter FSM: latch byte, shift out start, data LSB first, stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_done_q <= 1'b0;
      if (!txEn) begin
        tx_state_q <= TX_IDLE;
        tx_busy_q  <= 1'b0;
        tx_out_q   <= 1'b1;
      end else begin
        case (tx_state_q)
          TX_IDLE: begin
            if (txStart) begin
              tx_shift_q <= txIn;
              tx_out_q   <= 1'b0;
              tx_busy_q  <= 1'b1;
              tx_state_q <= TX_START;
            end
          end
          TX_START: begin
            if (tx_tick) begin
              tx_out_q   <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= '0;
              tx_state_q <= TX_DATA;
            end
          end
          TX_DATA: begin
            if (tx_tick) begin
              if (tx_bit_q == 3'd7) begin
                tx_out_q   <= 1'b1;
                tx_state_q <= TX_STOP;
              end else begin
                tx_out_q   <= tx_shift_q[0];
                tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                tx_bit_q   <= tx_bit_q + 3'd1;
              end
            end
          end
          TX_STOP: begin
            if (tx_tick) begin
              tx_done_q  <= 1'b1;
              tx_busy_q  <= 1'b0;
              tx_state_q <= TX_IDLE;
            end
          end
          default: begin
            tx_state_q <= TX_IDLE;
            tx_busy_q  <= 1'b0;
            tx_out_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rxBusy = rx_busy_q;
  assign rxDone = rx_done_q;
  assign rxErr  = rx_err_q;
  assign rxOut  = rx_out_q;
  assign txBusy = tx_busy_q;
  assign txDone = tx_done_q;
  assign txOut  = tx_out_q;

endmodule

// File: tb/tb_uart_8.sv
// Scoreboard bench for uart_8: stimulus pushes expected rx events and tx
// bytes; independent monitors pop and compare when the DUT reports them.
`timescale 1ns/1ps
module tb_uart_8;

  localparam int BIT_CLKS  = 1250;  // nominal bit at 12 MHz / 9600
  localparam int SLOW_CLKS = 1290;  // 107.5 us per bit at 12 MHz

  logic       clk = 1'b0;
  logic       reset;
  logic       rxEn, rx_drv, loop_en;
  logic       rxIn;
  logic       rxBusy, rxDone, rxErr;
  logic [7:0] rxOut;
  logic       txEn, txStart;
  logic [7:0] txIn;
  logic       txBusy, txDone, txOut;

  assign rxIn = loop_en ? txOut : rx_drv;

  uart_8 #(
    .CLOCK_RATE   (12000000),
    .BAUD_RATE    (9600),
    .RX_OVERSAMPLE(16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rxEn   (rxEn),
    .rxIn   (rxIn),
    .rxBusy (rxBusy),
    .rxDone (rxDone),
    .rxErr  (rxErr),
    .rxOut  (rxOut),
    .txEn   (txEn),
    .txStart(txStart),
    .txIn   (txIn),
    .txBusy (txBusy),
    .txDone (txDone),
    .txOut  (txOut)
  );

  always #41.667 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } rx_ev_t;

  int         checks   = 0;
  int         failures = 0;
  rx_ev_t     rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  logic [7:0] last_rx_byte;
  bit         tx_mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input int clks, input bit stop_val);
    logic [9:0] f;
    f = {stop_val, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      cycles(clks);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxBusy"}, rxBusy, 0);
    check({tag, "_rxDone"}, rxDone, 0);
    check({tag, "_rxErr"},  rxErr,  0);
    check({tag, "_rxOut"},  rxOut,  8'h00);
    check({tag, "_txBusy"}, txBusy, 0);
    check({tag, "_txDone"}, txDone, 0);
    check({tag, "_txOut"},  txOut,  1);
  endtask

  // Receive monitor: every rxDone or rising rxErr must match the next expectation.
  bit err_prev  = 1'b0;
  bit done_prev = 1'b0;
  always @(negedge clk) begin
    rx_ev_t ev;
    if (!reset) begin
      if (done_prev) check("rx_done_pulse_width", rxDone, 0);
      if (rxDone || (rxErr && !err_prev)) begin
        if (rx_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected_event actual=%0b%0b expected=none", rxErr, rxDone);
        end else begin
          ev = rx_exp_q.pop_front();
          check("rx_event_kind", {rxErr, rxDone}, ev.is_err ? 2'b10 : 2'b01);
          if (ev.is_err) begin
            check("rx_out_kept_on_err", rxOut, last_rx_byte);
          end else begin
            check("rx_data", rxOut, ev.data);
            last_rx_byte = ev.data;
          end
        end
      end
    end
    err_prev  = rxErr;
    done_prev = rxDone;
  end

  // Transmit frame checker, started on the falling edge of the start bit.
  task automatic tx_frame_check();
    logic [7:0] b;
    logic [9:0] f;
    int         off;
    int         target;
    if (tx_exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL tx_unexpected_frame actual=start expected=idle");
      return;
    end
    b   = tx_exp_q.pop_front();
    f   = {1'b1, b, 1'b0};
    off = 0;
    check("tx_busy_in_frame", txBusy, 1);
    for (int k = 0; k < 10; k++) begin
      target = 625 + BIT_CLKS * k;
      repeat (target - off) @(negedge clk);
      off = target;
      check($sformatf("tx_bit%0d", k), txOut, f[k]);
      if (k == 0) begin
        repeat (BIT_CLKS - 1 - off) @(negedge clk);
        check("tx_start_last_clk", txOut, 0);
        @(negedge clk);
        off = BIT_CLKS;
        check("tx_bit0_first_clk", txOut, b[0]);
      end
    end
    repeat (10 * BIT_CLKS - 1 - off) @(negedge clk);
    check("tx_done_not_early", txDone, 0);
    @(negedge clk);
    check("tx_done_pulse", txDone, 1);
    check("tx_busy_falls_with_done", txBusy, 0);
    check("tx_line_idle_after", txOut, 1);
  endtask

  initial begin
    bit prev_tx;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && !reset && prev_tx && !txOut) tx_frame_check();
      prev_tx = txOut;
    end
  end

  // Main stimulus.
  initial begin
    logic [7:0] b;
    logic [9:0] f;
    bit         seen;
    int         n;
    int         rate;
    rx_ev_t     ev;

    reset = 1'b1; rxEn = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    txEn = 1'b0; txStart = 1'b0; txIn = 8'h00;
    tx_mon_en = 1'b1; last_rx_byte = 8'h00;
    cycles(5);
    check_reset_outputs("reset");
    reset = 1'b0;
    cycles(5);

    // Line already low when the receiver is enabled: no frame may start.
    rx_drv = 1'b0;
    cycles(10);
    rxEn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rxBusy) seen = 1'b1;
    end
    check("rx_no_start_on_low_enable", seen, 0);
    #1;
    rx_drv = 1'b1;
    cycles(50);

    // Frame 0x35 at a slow (+3.2%) line rate.
    ev.is_err = 1'b0; ev.data = 8'h35; rx_exp_q.push_back(ev);
    drive_frame(8'h35, SLOW_CLKS, 1'b1);
    cycles(600);

    // Same frame with the stop bit low: framing error until the line rises.
    ev.is_err = 1'b1; ev.data = 8'h35; rx_exp_q.push_back(ev);
    drive_frame(8'h35, SLOW_CLKS, 1'b0);
    cycles(500);
    check("rx_err_held_while_low", rxErr, 1);
    check("rx_out_after_err", rxOut, 8'h35);
    rx_drv = 1'b1;
    cycles(10);
    check("rx_err_cleared_on_high", rxErr, 0);
    cycles(600);

    // Three-tick low glitch: start qualification fails silently.
    rx_drv = 1'b0;
    cycles(3 * 78);
    check("glitch_enters_start", rxBusy, 1);
    rx_drv = 1'b1;
    cycles(1500);
    check("glitch_back_idle", rxBusy, 0);
    check("glitch_no_err", rxErr, 0);

    // Transmitter with loopback into the receiver.
    loop_en = 1'b1;
    txEn    = 1'b1;
    cycles(20);
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? 8'hA5 : 8'($urandom);
      n = 0;
      while (txBusy && n < 20000) begin cycles(1); n++; end
      check("tx_idle_before_start", txBusy, 0);
      txIn = b; txStart = 1'b1;
      tx_exp_q.push_back(b);
      ev.is_err = 1'b0; ev.data = b; rx_exp_q.push_back(ev);
      cycles(1);
      txStart = 1'b0;
      check("tx_busy_rise", txBusy, 1);
      if (i == 0) begin
        cycles(3000);
        txIn = ~b; txStart = 1'b1;
        cycles(1);
        txStart = 1'b0;
      end
      n = 0;
      while (!txDone && n < 13000) begin cycles(1); n++; end
      check("tx_done_seen", txDone, 1);
    end
    cycles(300);
    loop_en = 1'b0;

    // Transmitter abort via txEn.
    tx_mon_en = 1'b0;
    txIn = 8'($urandom); txStart = 1'b1;
    cycles(1);
    txStart = 1'b0;
    cycles(3000);
    check("tx_busy_before_abort", txBusy, 1);
    txEn = 1'b0;
    cycles(1);
    check("tx_abort_line_high", txOut, 1);
    check("tx_abort_not_busy", txBusy, 0);
    cycles(20);
    txEn = 1'b1;
    cycles(20);
    check("tx_after_abort_idle", txOut, 1);
    check("tx_after_abort_busy", txBusy, 0);
    tx_mon_en = 1'b1;

    // Reset in the middle of data bit 4 discards the partial byte.
    b = 8'($urandom);
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rx_drv = f[k];
      cycles(BIT_CLKS);
    end
    rx_drv = f[5];
    cycles(625);
    check("rx_busy_in_data", rxBusy, 1);
    #10;
    reset = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    rx_drv = 1'b1;
    last_rx_byte = 8'h00;
    cycles(5);
    reset = 1'b0;
    cycles(300);

    // Next frame at a randomly chosen rate within tolerance.
    b = 8'($urandom);
    case ($urandom_range(0, 2))
      0:       rate = 1215;
      1:       rate = BIT_CLKS;
      default: rate = 1285;
    endcase
    ev.is_err = 1'b0; ev.data = b; rx_exp_q.push_back(ev);
    drive_frame(b, rate, 1'b1);
    cycles(600);

    n = 0;
    while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && n < 20000) begin
      cycles(1);
      n++;
    end
    check("rx_scoreboard_drained", rx_exp_q.size(), 0);
    check("tx_scoreboard_drained", tx_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
